uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Line-granular arbiter sharing one testbench/SoC UART transmit byte stream among `NUM_REQ` requesters (cores, debug agents, BFMs). Grant is held from a requester's first byte until it sends newline (8'h0a), hits a line-length limit or goes idle too long, so lines never interleave on the wire. Sits between the requesters and the UART transmitter byte interface; the receive-side line logger then sees whole lines.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `MAX_LINE`, 132: maximum bytes per grant, newline included.
- `IDLE_TIMEOUT`, 1024: consecutive cycles with `req_valid[grant_id]`=0 before forced release.
- `clk  in  1`: single clock.
- `reset  in  1`: synchronous, active-high reset.
- `req_valid  in  NUM_REQ`: per-requester byte valid.
- `req_data  in  NUM_REQ*8`: byte of requester i at [8i+7:8i].
- `req_ready  out  NUM_REQ`: per-requester accept.
- `tx_valid  out  1`: byte valid to UART transmitter.
- `tx_data  out  8`: byte to UART transmitter.
- `tx_ready  in  1`: transmitter accepts byte (not busy).
- `grant_active  out  1`: a requester holds the line.
- `grant_id  out  $clog2(NUM_REQ)`: current/last granted requester.
- `trunc_evt  out  1`: one-cycle pulse on release by length or timeout.

## Operation
- Handshake per port: transfer when valid && ready. Producers must not drop valid or change data before the transfer. `tx_valid` never depends on `tx_ready`.
- States: IDLE, LOCK, INJECT (INJECT exists only with macro).
- IDLE: `grant_active`=0, all `req_ready`=0, `tx_valid`=0, `tx_data`=0. If any `req_valid`, pick first set bit searching from `last_grant+1` modulo NUM_REQ (round-robin). Register `grant_id` and go to LOCK. Clear `byte_cnt` and `idle_cnt`.
- LOCK: combinational pass-through. `tx_valid`=`req_valid[grant_id]`, `tx_data`=`req_data[grant_id]`, `req_ready[grant_id]`=`tx_ready`. All other `req_ready`=0.
- On an accepted byte:
  - `byte_cnt`++ and `idle_cnt` cleared.
  - Byte 8'h0a: release normally.
  - Otherwise, if `byte_cnt`==MAX_LINE-1 before increment: truncation release.
- `idle_cnt` increments only on cycles with `req_valid[grant_id]`=0. A stall from `tx_ready`=0 is not idle. `idle_cnt`==IDLE_TIMEOUT-1 with no valid: timeout release.
- Release: `last_grant`<=`grant_id`, go IDLE. Truncation and timeout releases also pulse `trunc_evt`.
- Precedence in one cycle: newline > length > timeout. A byte accepted on the timeout cycle cancels the timeout.
- Counter widths: `byte_cnt` $clog2(MAX_LINE+1); `idle_cnt` $clog2(IDLE_TIMEOUT+1). Neither counter wraps; both saturate by construction.

## Timing
- Reset values: state IDLE, `last_grant`=NUM_REQ-1 so requester 0 wins first, `grant_id`=0, `grant_active`=0, `tx_valid`=0, `tx_data`=0, `req_ready`=0, `trunc_evt`=0, counters 0.
- Arbitration latency: `req_valid` seen in IDLE at cycle N gives `grant_active`=1 and pass-through at N+1. Data latency through LOCK is 0 cycles.
- Release: the cycle after the releasing transfer is IDLE, so one dead cycle. The next grant is at the earliest 2 cycles after the last byte.
- `trunc_evt` asserts in the cycle after the releasing event, for 1 cycle.
- Reset mid-line: back to IDLE next edge. A partial line is abandoned with no injected newline.
- A requester deasserting valid mid-line keeps its grant until newline or timeout.

## Configuration
- `UART_ARB_FORCE_NL_EN` defined: truncation or timeout release goes LOCK→INJECT instead of IDLE.
  - INJECT drives `tx_valid`=1, `tx_data`=8'h0a, all `req_ready`=0.
  - On `tx_ready`, go IDLE. `trunc_evt` pulses on the INJECT→IDLE transition.
  - Effect: every line on the wire ends in a newline.
- Undefined: release goes directly to IDLE. No state, logic or byte is injected.

## Structure
- Package `uart_arb_pkg`: state enum `uart_arb_state_t` {IDLE, LOCK, INJECT} and constant `UART_NL`=8'h0a.
- Sub-module `uart_rr_pick`: rotating priority encoder (inputs request vector and last grant; outputs found and index), reusable by other CEP arbiters.
- Counters and FSM stay in `uart_tx_arbiter`.

## Test plan
- Req0 sends "AB\n" while req2 holds valid with 'x', `tx_ready`=1 → tx sees 41,42,0a, one dead cycle, then req2 granted with `grant_id`=2.
- All 4 requesters send one "\n" each, continuously valid → grant order 0,1,2,3,0; no interleaving.
- Req1 streams 140 bytes with no newline, MAX_LINE=132 → 132 bytes passed, `trunc_evt` pulse; with macro a 133rd byte 0a is injected.
- Req0 sends "A" then stops; IDLE_TIMEOUT=16 → release after 16 idle cycles, `trunc_evt`=1, req3 then granted; `tx_ready`=0 stalls of 100 cycles cause no timeout.
- `tx_ready` toggles every cycle during "HELLO\n" → bytes delivered in order and exactly once; `tx_valid` stable while stalled.
- `reset` asserted mid-line on byte 3 → next cycle all outputs at reset values; the first post-reset grant goes to req0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the line-granular UART transmit arbiter.
// Optional newline injection is enabled with UART_ARB_FORCE_NL_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK   = 2'd1,
        INJECT = 2'd2
    } uart_arb_state_t;

    localparam logic [7:0] UART_NL = 8'h0a;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating priority encoder: returns the first set request searching upward
// from last_i+1 (mod N), so the previous winner has the lowest priority.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N;
        return IW'(s);
    endfunction

    logic [IW-1:0] cand_idx [N];
    logic [N-1:0]  rot;

    // rot[gi] is the request that sits gi+1 places after the last winner
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign cand_idx[gi] = wrap(last_i, gi + 1);
        assign rot[gi]      = req_i[cand_idx[gi]];
    end

    always_comb begin
        found_o = |rot;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx_o = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit byte stream among NUM_REQ requesters, one whole line
// per grant. Define UART_ARB_FORCE_NL_EN to terminate cut-off lines with a newline.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_LINE     = 132,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       trunc_evt
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_LINE + 1);
    localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(MAX_LINE - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TIMEOUT - 1);

    uart_arb_state_t state_q, state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
    logic            trunc_q, trunc_d;

    logic            sel_valid;
    logic [7:0]      sel_data;
    logic            xfer;
    logic            force_rel;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    assign sel_valid = req_valid[grant_id_q];
    assign sel_data  = req_data[grant_id_q*8 +: 8];
    assign xfer      = sel_valid && tx_ready;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            trunc_q      <= trunc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        trunc_d      = 1'b0;
        force_rel    = 1'b0;
        case (state_q)
            IDLE: begin
                byte_cnt_d = '0;
                idle_cnt_d = '0;
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                // newline beats length; any accepted byte cancels a timeout
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    idle_cnt_d = '0;
                    if (sel_data == UART_NL) begin
                        last_grant_d = grant_id_q;
                        state_d      = IDLE;
                    end else if (byte_cnt_q == BYTE_LAST) begin
                        force_rel = 1'b1;
                    end
                end else if (!sel_valid) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        force_rel = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + ICW'(1);
                    end
                end
                if (force_rel) begin
                    last_grant_d = grant_id_q;
`ifdef UART_ARB_FORCE_NL_EN
                    state_d = INJECT;
`else
                    state_d = IDLE;
                    trunc_d = 1'b1;
`endif
                end
            end
`ifdef UART_ARB_FORCE_NL_EN
            INJECT: begin
                if (tx_ready) begin
                    state_d = IDLE;
                    trunc_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        grant_active = 1'b0;
        case (state_q)
            LOCK: begin
                tx_valid             = sel_valid;
                tx_data              = sel_data;
                req_ready[grant_id_q] = tx_ready;
                grant_active         = 1'b1;
            end
`ifdef UART_ARB_FORCE_NL_EN
            INJECT: begin
                tx_valid     = 1'b1;
                tx_data      = UART_NL;
                grant_active = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign grant_id  = grant_id_q;
    assign trunc_evt = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written sequences
// for truncation, timeout, stalls and mid-line reset.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int ML = 132;
    localparam int IT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        trunc_evt;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .MAX_LINE     (ML),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .trunc_evt    (trunc_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic        tv;
        logic [7:0]  td;
        logic [3:0]  rr;
        logic        ga;
        logic [1:0]  gid;
        logic        tr;
    } vec_t;

    vec_t vecs [18];

    logic [7:0] hello [6];
    logic [7:0] got   [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [16:0] outs();
        return {tx_valid, tx_data, req_ready, grant_active, grant_id, trunc_evt};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                                input logic rdy, input logic tv, input logic [7:0] td,
                                input logic [3:0] rr, input logic ga, input logic [1:0] gid,
                                input logic tr);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.rdy = rdy;
        v.tv = tv; v.td = td; v.rr = rr; v.ga = ga; v.gid = gid; v.tr = tr;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input int p);
        return 8'h41 + 8'(p % 26);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, pos, errs, stab_err, idx, wcnt;
        logic seen, last_ga, prev_stalled;
        logic [7:0] prev_data, exp_b;

        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4c;
        hello[3] = 8'h4c; hello[4] = 8'h4f; hello[5] = 8'h0a;

        // req0 "AB\n" while req2 waits with 'x', then req2's line
        vecs[0]  = mk(1, 4'b0101, 32'h0078_0041, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        vecs[1]  = mk(0, 4'b0101, 32'h0078_0041, 1, 1, 8'h41, 4'b0001, 1, 2'd0, 0);
        vecs[2]  = mk(0, 4'b0101, 32'h0078_0042, 1, 1, 8'h42, 4'b0001, 1, 2'd0, 0);
        vecs[3]  = mk(0, 4'b0101, 32'h0078_000a, 1, 1, 8'h0a, 4'b0001, 1, 2'd0, 0);
        vecs[4]  = mk(0, 4'b0100, 32'h0078_0000, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        vecs[5]  = mk(0, 4'b0100, 32'h0078_0000, 1, 1, 8'h78, 4'b0100, 1, 2'd2, 0);
        vecs[6]  = mk(0, 4'b0100, 32'h000a_0000, 1, 1, 8'h0a, 4'b0100, 1, 2'd2, 0);
        vecs[7]  = mk(0, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 0, 2'd2, 0);
        // everyone sends "\n" back to back: 0,1,2,3,0
        vecs[8]  = mk(1, 4'b1111, 32'h0a0a_0a0a, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        vecs[9]  = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 1, 8'h0a, 4'b0001, 1, 2'd0, 0);
        vecs[10] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        vecs[11] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 1, 8'h0a, 4'b0010, 1, 2'd1, 0);
        vecs[12] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 0, 8'h00, 4'b0000, 0, 2'd1, 0);
        vecs[13] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 1, 8'h0a, 4'b0100, 1, 2'd2, 0);
        vecs[14] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 0, 8'h00, 4'b0000, 0, 2'd2, 0);
        vecs[15] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 1, 8'h0a, 4'b1000, 1, 2'd3, 0);
        vecs[16] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 0, 8'h00, 4'b0000, 0, 2'd3, 0);
        vecs[17] = mk(0, 4'b1111, 32'h0a0a_0a0a, 1, 1, 8'h0a, 4'b0001, 1, 2'd0, 0);

        reset = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                chk($sformatf("vec%0d_reset_state", i), 32'(outs()), 32'h0);
            end
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            tx_ready  = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].tv, vecs[i].td, vecs[i].rr, vecs[i].ga, vecs[i].gid, vecs[i].tr}));
            $display("vec %0d: tx_valid=%0b tx_data=%02h req_ready=%04b grant_id=%0d",
                     i, tx_valid, tx_data, req_ready, grant_id);
            tick();
        end

        // req1 streams without newline: cut at MAX_LINE
        do_reset();
        req_valid = 4'b0010;
        pos = 0; w = 0; errs = 0; seen = 1'b0; last_ga = 1'b1;
        set_byte(1, byte_of(0));
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (trunc_evt) begin
                seen    = 1'b1;
                last_ga = grant_active;
            end
            if (tx_valid && tx_ready) begin
                exp_b = (w < ML) ? byte_of(w) : 8'h0a;
                if (tx_data != exp_b) errs++;
                w++;
            end
            if (req_ready[1] && req_valid[1]) pos++;
            tick();
            set_byte(1, byte_of(pos));
        end
        $display("trunc: %0d bytes on wire, %0d accepted from req1", w, pos);
        chk("trunc_seen", 32'(seen), 32'd1);
`ifdef UART_ARB_FORCE_NL_EN
        chk("trunc_wire_len", 32'(w), 32'(ML + 1));
`else
        chk("trunc_wire_len", 32'(w), 32'(ML));
`endif
        chk("trunc_req_accepted", 32'(pos), 32'(ML));
        chk("trunc_order", 32'(errs), 32'd0);
        chk("trunc_released", 32'(last_ga), 32'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("trunc_pulse_1cyc", 32'({trunc_evt, grant_active, grant_id}), 32'({1'b0, 1'b1, 2'd1}));
        tick();

        // req0 sends 'A' and goes quiet; req3 waits
        do_reset();
        req_valid = 4'b1001;
        set_byte(0, 8'h41);
        set_byte(3, 8'h5a);
        tick();
        @(negedge clk);
        chk("to_a_xfer", 32'({tx_valid, tx_data, req_ready}), 32'({1'b1, 8'h41, 4'b0001}));
        tick();
        req_valid = 4'b1000;
        tx_ready  = 1'b0;
        errs = 0;
        for (int k = 0; k < IT; k++) begin
            @(negedge clk);
            if (!grant_active || grant_id != 2'd0 || trunc_evt) errs++;
            tick();
        end
        chk("to_hold_16", 32'(errs), 32'd0);
`ifdef UART_ARB_FORCE_NL_EN
        tx_ready = 1'b1;
        @(negedge clk);
        chk("to_inject", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h0a}));
        tick();
        tx_ready = 1'b0;
`endif
        @(negedge clk);
        chk("to_release", 32'({grant_active, trunc_evt}), 32'b01);
        tick();
        @(negedge clk);
        chk("to_regrant", 32'({grant_active, grant_id, tx_valid, tx_data, trunc_evt, req_ready}),
            32'({1'b1, 2'd3, 1'b1, 8'h5a, 1'b0, 4'b0000}));
        tick();
        // 100 cycles of transmitter stall are not idle time
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!grant_active || grant_id != 2'd3 || trunc_evt || !tx_valid ||
                tx_data != 8'h5a || req_ready != 4'b0000) errs++;
            tick();
        end
        chk("stall_no_timeout", 32'(errs), 32'd0);
        set_byte(3, 8'h0a);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("stall_nl_xfer", 32'({tx_valid, tx_data, req_ready}), 32'({1'b1, 8'h0a, 4'b1000}));
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("stall_nl_release", 32'({grant_active, trunc_evt}), 32'b00);
        tick();

        // "HELLO\n" from req2 with tx_ready toggling
        do_reset();
        req_valid = 4'b0100;
        idx = 0; wcnt = 0; errs = 0; stab_err = 0; prev_stalled = 1'b0; prev_data = 8'h00;
        set_byte(2, hello[0]);
        for (int c = 0; c < 40 && idx < 6; c++) begin
            tx_ready = c[0];
            @(negedge clk);
            if (prev_stalled && (!tx_valid || tx_data != prev_data)) stab_err++;
            prev_stalled = tx_valid && !tx_ready;
            prev_data    = tx_data;
            if (tx_valid && tx_ready) begin
                if (wcnt < 8) got[wcnt] = tx_data;
                $display("hello: wire byte %0d = %02h", wcnt, tx_data);
                wcnt++;
            end
            if (req_ready[2] && req_valid[2]) idx++;
            tick();
            if (idx < 6) set_byte(2, hello[idx]);
            else req_valid = 4'b0000;
        end
        chk("hello_count", 32'(wcnt), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (got[k] != hello[k]) errs++;
        end
        chk("hello_bytes", 32'(errs), 32'd0);
        chk("hello_stable", 32'(stab_err), 32'd0);
        @(negedge clk);
        chk("hello_released", 32'({grant_active, tx_valid}), 32'b00);
        tick();

        // reset while req1's third byte is on the wire
        do_reset();
        req_valid = 4'b0010;
        tx_ready  = 1'b1;
        set_byte(1, 8'h41);
        tick();
        @(negedge clk);
        chk("mid_b1", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h41}));
        tick();
        set_byte(1, 8'h42);
        @(negedge clk);
        chk("mid_b2", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h42}));
        tick();
        set_byte(1, 8'h43);
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset     = 1'b0;
        req_valid = 4'b0111;
        chk("mid_reset_state", 32'(outs()), 32'h0);
        tick();
        chk("post_reset_grant", 32'({grant_active, grant_id}), 32'({1'b1, 2'd0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
